// File: rtl/decode_issue_ctrl.sv
// decode_issue_ctrl: RV64I decode-stage issue controller (ID slot + EX-issue register, load-use bubble, flush, immediates)
// Ports: clk/reset_n (async active-low); fetch side if_valid/if_instr/if_pc with id_ready;
//        flush kills both slots; execute side ex_ready with ex_valid/ex_instr/ex_pc/ex_imm/
//        ex_rs1/ex_rs2/ex_rd/ex_is_load; hazard_cnt counts inserted bubbles (saturating).
module decode_issue_ctrl #(
    parameter int HCNT_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              if_valid,
    input  logic [31:0]       if_instr,
    input  logic [63:0]       if_pc,
    output logic              id_ready,
    input  logic              flush,
    input  logic              ex_ready,
    output logic              ex_valid,
    output logic [31:0]       ex_instr,
    output logic [63:0]       ex_pc,
    output logic [63:0]       ex_imm,
    output logic [4:0]        ex_rs1,
    output logic [4:0]        ex_rs2,
    output logic [4:0]        ex_rd,
    output logic              ex_is_load,
    output logic [HCNT_W-1:0] hazard_cnt
);
    typedef enum logic [1:0] {EMPTY, HOLD, BUBBLE} state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OP32   = 7'b0111011;

    function automatic logic uses_rs1(input logic [6:0] op);
        return !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
    endfunction

    function automatic logic uses_rs2(input logic [6:0] op);
        return op == OP_OP || op == OP_OP32 || op == OP_STORE || op == OP_BRANCH;
    endfunction

    function automatic logic load_use(input logic idv, input logic [6:0] op, input logic [4:0] rs1,
                                      input logic [4:0] rs2, input logic exl, input logic [4:0] rd);
        return idv & exl & (rd != 5'd0) &
               ((uses_rs1(op) & (rd == rs1)) | (uses_rs2(op) & (rd == rs2)));
    endfunction

    function automatic logic [63:0] imm_gen(input logic [31:0] i);
        case (i[6:0])
            OP_LOAD, OP_IMM, OP_IMM32, OP_JALR, OP_SYSTEM:
                return {{52{i[31]}}, i[31:20]};
            OP_STORE:  return {{52{i[31]}}, i[31:25], i[11:7]};
            OP_BRANCH: return {{51{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            OP_LUI, OP_AUIPC: return {{32{i[31]}}, i[31:12], 12'b0};
            OP_JAL:    return {{43{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default:   return 64'd0;
        endcase
    endfunction

    state_t            state_q, state_d;
    logic [31:0]       id_instr_q, id_instr_d;
    logic [63:0]       id_pc_q, id_pc_d;
    logic              ex_valid_q, ex_valid_d;
    logic [31:0]       ex_instr_q, ex_instr_d;
    logic [63:0]       ex_pc_q, ex_pc_d;
    logic [63:0]       ex_imm_q, ex_imm_d;
    logic [HCNT_W-1:0] hcnt_q, hcnt_d;
    logic              id_valid, hazard, ex_adv, issue, load_id, idv_d, clr_ex;

    // BUBBLE encodes "ID holds an instruction that depends on the load in EX"
    assign id_valid = state_q != EMPTY;
    assign hazard   = state_q == BUBBLE;
    assign ex_adv   = ~ex_valid_q | ex_ready;
    assign issue    = ~flush & ex_adv & id_valid & ~hazard;
    assign id_ready = flush | ~id_valid | (ex_adv & ~hazard);
    assign load_id  = ~flush & if_valid & id_ready;
    // EX is emptied (and zeroed) on flush, on a bubble, or when consumed with nothing behind it
    assign clr_ex   = flush | (ex_adv & ~issue);

    always_comb begin
        ex_valid_d = issue ? 1'b1 : clr_ex ? 1'b0 : ex_valid_q;
        ex_instr_d = issue ? id_instr_q : clr_ex ? 32'd0 : ex_instr_q;
        ex_pc_d    = issue ? id_pc_q : clr_ex ? 64'd0 : ex_pc_q;
        ex_imm_d   = issue ? imm_gen(id_instr_q) : clr_ex ? 64'd0 : ex_imm_q;
        id_instr_d = load_id ? if_instr : id_instr_q;
        id_pc_d    = load_id ? if_pc : id_pc_q;
        idv_d      = load_id | (id_valid & ~issue & ~flush);
        hcnt_d     = (~flush & ex_adv & hazard & ~&hcnt_q) ? hcnt_q + 1'b1 : hcnt_q;
        // classify the next ID/EX pair so the hazard is a registered state
        state_d    = ~idv_d ? EMPTY :
                     load_use(idv_d, id_instr_d[6:0], id_instr_d[19:15], id_instr_d[24:20],
                              ex_valid_d & (ex_instr_d[6:0] == OP_LOAD), ex_instr_d[11:7]) ? BUBBLE : HOLD;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= EMPTY;
            id_instr_q <= '0;
            id_pc_q    <= '0;
            ex_valid_q <= 1'b0;
            ex_instr_q <= '0;
            ex_pc_q    <= '0;
            ex_imm_q   <= '0;
            hcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            id_instr_q <= id_instr_d;
            id_pc_q    <= id_pc_d;
            ex_valid_q <= ex_valid_d;
            ex_instr_q <= ex_instr_d;
            ex_pc_q    <= ex_pc_d;
            ex_imm_q   <= ex_imm_d;
            hcnt_q     <= hcnt_d;
        end
    end

    // bubbles carry a zero word, so the decoded fields and load flag fall to 0 with it
    assign ex_valid   = ex_valid_q;
    assign ex_instr   = ex_instr_q;
    assign ex_pc      = ex_pc_q;
    assign ex_imm     = ex_imm_q;
    assign ex_rs1     = ex_instr_q[19:15];
    assign ex_rs2     = ex_instr_q[24:20];
    assign ex_rd      = ex_instr_q[11:7];
    assign ex_is_load = ex_instr_q[6:0] == OP_LOAD;
    assign hazard_cnt = hcnt_q;
endmodule
